// File: rtl/tx_retry_ctrl.sv
// tx_retry_ctrl: loads a packet from the TX FIFO into a local buffer, streams it to the PHY, and resends it on nak or timeout.
module tx_retry_ctrl #(
  parameter int PKT_WORDS = 8,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_flush,
  input  logic [CNT_W-1:0] fifo_words,
  output logic             fifo_rd_en,
  input  logic [31:0]      fifo_dout,
  output logic             phy_valid,
  output logic [31:0]      phy_data,
  input  logic             phy_ready,
  output logic             timer_start,
  input  logic             timer_done,
  input  logic             rx_ack,
  input  logic             rx_nak,
  output logic             busy,
  output logic             pkt_done,
  output logic             pkt_err,
  output logic [CNT_W-1:0] retry_cnt
);
  localparam int IW = PKT_WORDS > 1 ? $clog2(PKT_WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(PKT_WORDS - 1);
  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, pc_q, pc_d;
  logic rd_q, rd_d, cap_q, cap_d, valid_q, valid_d, ts_q, ts_d, done_q, done_d, err_q, err_d;
  logic [31:0] data_q, data_d;
  logic [CNT_W-1:0] retry_q, retry_d;
  logic [31:0] mem_q [PKT_WORDS];
  logic hs, fire;
  assign hs   = valid_q && phy_ready;
  assign fire = rx_nak || timer_done;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pc_d    = pc_q;
    rd_d    = rd_q;
    cap_d   = rd_q;
    valid_d = valid_q;
    data_d  = data_q;
    retry_d = retry_q;
    ts_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (32'(fifo_words) >= PKT_WORDS) begin
        state_d = LOAD;
        rd_d    = 1'b1;
        pc_d    = '0;
        idx_d   = '0;
        retry_d = '0;
      end
      LOAD: begin
        if (rd_q) begin
          pc_d = pc_q + 1'b1;
          rd_d = pc_q != LAST;
        end
        if (cap_q) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST) begin
            state_d = SEND;
            idx_d   = '0;
            valid_d = 1'b1;
            // a one-word packet is still being written into mem_q this cycle
            data_d  = idx_q == '0 ? fifo_dout : mem_q[0];
          end
        end
      end
      SEND: if (hs) begin
        if (idx_q == LAST) begin
          state_d = WAIT;
          valid_d = 1'b0;
          ts_d    = 1'b1;
          idx_d   = '0;
        end else begin
          idx_d  = idx_q + 1'b1;
          data_d = mem_q[idx_q + 1'b1];
        end
      end
      WAIT: begin
        if (rx_ack) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (fire) begin
          if (retry_q < CNT_W'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = SEND;
            valid_d = 1'b1;
            data_d  = mem_q[0];
            idx_d   = '0;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (reg_flush) begin
      state_d = IDLE;
      valid_d = 1'b0;
      rd_d    = 1'b0;
      cap_d   = 1'b0;
      idx_d   = '0;
      pc_d    = '0;
      retry_d = '0;
      ts_d    = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pc_q    <= '0;
      rd_q    <= 1'b0;
      cap_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      retry_q <= '0;
      ts_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      cap_q   <= cap_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      retry_q <= retry_d;
      ts_q    <= ts_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (cap_q && state_q == LOAD) mem_q[idx_q] <= fifo_dout;
  end
  assign fifo_rd_en  = rd_q;
  assign phy_valid   = valid_q;
  assign phy_data    = data_q;
  assign timer_start = ts_q;
  assign busy        = state_q != IDLE;
  assign pkt_done    = done_q;
  assign pkt_err     = err_q;
  assign retry_cnt   = retry_q;
endmodule

// File: tb/tb_tx_retry_ctrl.sv
// tb_tx_retry_ctrl: randomized bench for tx_retry_ctrl with a FIFO model and a packet-level retry reference.
module tb_tx_retry_ctrl;
  localparam int PW = 8;
  localparam int MR = 3;
  localparam int CW = 4;
  logic clk = 1'b0, rst = 1'b1, reg_flush = 1'b0, phy_ready = 1'b0;
  logic timer_done = 1'b0, rx_ack = 1'b0, rx_nak = 1'b0;
  logic [CW-1:0] fifo_words = '0;
  logic [31:0] fifo_dout = '0;
  logic fifo_rd_en, phy_valid, timer_start, busy, pkt_done, pkt_err;
  logic [31:0] phy_data;
  logic [CW-1:0] retry_cnt;
  always #5 clk = ~clk;
  tx_retry_ctrl #(.PKT_WORDS(PW), .MAX_RETRY(MR), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .reg_flush(reg_flush), .fifo_words(fifo_words),
    .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .phy_valid(phy_valid),
    .phy_data(phy_data), .phy_ready(phy_ready), .timer_start(timer_start),
    .timer_done(timer_done), .rx_ack(rx_ack), .rx_nak(rx_nak), .busy(busy),
    .pkt_done(pkt_done), .pkt_err(pkt_err), .retry_cnt(retry_cnt)
  );
  int n_vec = 0, n_bad = 0;
  int pops = 0, ts_n = 0, done_n = 0, err_n = 0, bp_pct = 100;
  logic [31:0] fq[$], got[$], pkt[$];
  logic prev_stall = 1'b0, prev_flush = 1'b0, pend_v;
  logic [31:0] prev_data = '0, pend = '0, s_data;
  logic s_rd, s_valid, s_ts, s_done, s_err, s_busy;
  logic [CW-1:0] s_retry;
  task chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  // samples mid-cycle, then applies FIFO read data and new inputs just after the edge
  task cyc();
    @(negedge clk);
    if (prev_stall && !prev_flush) chk("stall_hold", {phy_valid, phy_data}, {1'b1, prev_data});
    prev_stall = phy_valid && !phy_ready;
    prev_data  = phy_data;
    prev_flush = reg_flush;
    {s_rd, s_valid, s_ts, s_done, s_err, s_busy, s_retry, s_data} =
      {fifo_rd_en, phy_valid, timer_start, pkt_done, pkt_err, busy, retry_cnt, phy_data};
    if (phy_valid && phy_ready) got.push_back(phy_data);
    ts_n   += int'(timer_start);
    done_n += int'(pkt_done);
    err_n  += int'(pkt_err);
    pend_v = fifo_rd_en;
    if (fifo_rd_en) begin
      pops++;
      pend = fq.size() > 0 ? fq.pop_front() : 32'hdeadbeef;
    end
    @(posedge clk);
    #1;
    if (pend_v) fifo_dout = pend;
    fifo_words = CW'(fq.size() > 15 ? 15 : fq.size());
    phy_ready = $urandom_range(99) < bp_pct;
  endtask
  task push_pkt();
    pkt.delete();
    got.delete();
    pops = 0;
    for (int i = 0; i < PW; i++) begin
      pkt.push_back($urandom);
      fq.push_back(pkt[i]);
    end
  endtask
  task wait_ts(output bit ok);
    int t;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      t = ts_n;
      cyc();
      if (ts_n != t) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("ts_timeout", 0, 1);
  endtask
  task check_words();
    chk("word_count", got.size(), PW);
    for (int i = 0; i < PW && i < got.size(); i++) chk("word", got[i], pkt[i]);
    got.delete();
  endtask
  // sched holds {ack,nak,timeout} per attempt; rnd draws them instead
  task run_pkt(input logic [11:0] sched, input bit rnd);
    int a, d0, e0, t0;
    bit ok;
    logic [2:0] ev;
    logic exp_err;
    push_pkt();
    d0 = done_n; e0 = err_n; t0 = ts_n;
    exp_err = 1'b0;
    for (a = 0; a <= MR; a++) begin
      wait_ts(ok);
      if (!ok) return;
      check_words();
      repeat (rnd ? $urandom_range(4) : 4) cyc();
      if (rnd) begin
        ev = 3'($urandom_range(1, 7));
        if ($urandom_range(2) != 0) ev[2] = 1'b0;
        if (ev == 3'b000) ev = 3'b010;
      end else ev = sched[3*a +: 3];
      {rx_ack, rx_nak, timer_done} = ev;
      cyc();
      {rx_ack, rx_nak, timer_done} = 3'b000;
      cyc();
      if (ev[2]) begin
        chk("done_pulse", s_done, 1);
        chk("retry_on_ack", s_retry, a);
        chk("busy_after_ack", s_busy, 0);
        break;
      end else if (a < MR) begin
        chk("retry_cnt", s_retry, a + 1);
        chk("busy_retry", s_busy, 1);
      end else begin
        exp_err = 1'b1;
        chk("err_pulse", s_err, 1);
        chk("retry_sat", s_retry, MR);
        chk("busy_after_err", s_busy, 0);
      end
    end
    if (a > MR) a = MR;
    chk("pops", pops, PW);
    chk("ts_count", ts_n - t0, a + 1);
    chk("done_err_count", {32'(done_n - d0), 32'(err_n - e0)}, {32'(!exp_err), 32'(exp_err)});
  endtask
  task run_flush();
    int d0, e0, t0;
    push_pkt();
    d0 = done_n; e0 = err_n; t0 = ts_n;
    for (int i = 0; i < 200 && got.size() < 3; i++) cyc();
    chk("flush_reach_word3", got.size() >= 3, 1);
    reg_flush = 1'b1;
    cyc();
    reg_flush = 1'b0;
    cyc();
    chk("flush_state", {s_valid, s_busy, s_rd, s_retry}, 0);
    repeat (6) cyc();
    chk("flush_pulses", {32'(ts_n - t0), 32'(done_n - d0), 32'(err_n - e0)}, 0);
    chk("flush_idle", s_busy, 0);
    chk("flush_pops", pops, PW);
    got.delete();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) cyc();
    chk("reset", {s_rd, s_valid, s_ts, s_done, s_err, s_busy, s_retry, s_data}, 0);
    rst = 1'b0;
    repeat (2) cyc();
    chk("idle_empty", s_busy, 0);
    run_pkt(12'b000_000_000_100, 1'b0);
    bp_pct = 50;
    run_pkt(12'b000_000_000_100, 1'b0);
    bp_pct = 100;
    run_pkt(12'b000_000_100_001, 1'b0);
    run_pkt(12'b010_010_010_010, 1'b0);
    run_pkt(12'b000_000_000_101, 1'b0);
    run_pkt(12'b000_000_100_011, 1'b0);
    run_flush();
    run_pkt(12'b000_000_000_100, 1'b0);
    for (int k = 0; k < 25; k++) begin
      bp_pct = $urandom_range(30, 100);
      run_pkt(12'b0, 1'b1);
      repeat ($urandom_range(3)) cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
